// File: rtl/io_guard_pkg.sv
// Shared definitions for the io_guard I/O-cycle monitor: FSM state
// encoding, permission-group geometry, the violation record layout and
// the violation predicate used by the top level.
package io_guard_pkg;

  // Permission geometry: 16 groups of 16 ports, group index = addr[7:4]
  localparam int PERM_GROUPS = 16;
  localparam int GROUP_SHIFT = 4;

  // Monitor FSM states
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACTIVE = 2'd1,
    ST_PULSE  = 2'd2
  } guard_state_t;

  // One captured violation: port, write data (zero for IN) and direction
  typedef struct packed {
    logic [7:0] addr;
    logic [7:0] data;
    logic       write;
  } viol_rec_t;

  // A cycle traps only while virtualised, outside trap mode, and when the
  // port's group has no allow bit set
  function automatic logic isViolation(
    input logic                   virtEn,
    input logic                   trapMode,
    input logic [PERM_GROUPS-1:0] mask,
    input logic [3:0]             group
  );
    return virtEn && !trapMode && !mask[group];
  endfunction

endpackage

// File: rtl/io_guard_sync.sv
// Multi-flop synchroniser for one asynchronous Z80 strobe. The chain
// resets to all ones so the strobe reads as inactive (high) after reset.
module io_sync #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic i_async,
  output logic o_sync
);

  logic [STAGES-1:0] r_chain;

  // Shift the raw pin through the chain; reset fills it with inactive ones
  always_ff @(posedge clk) begin
    if (rst) begin
      r_chain <= '1;
    end else begin
      r_chain <= {r_chain[STAGES-2:0], i_async};
    end
  end

  assign o_sync = r_chain[STAGES-1];

endmodule

// File: rtl/io_guard.sv
// io_guard: Z80 I/O-cycle monitor feeding the trap/mode controller.
// Classifies each synchronised I/O cycle against a 16-group allow mask,
// pulses io_violation for VIOL_PULSE clocks on a trapped access and keeps
// one violation record for the hypervisor.
// Optional build macro: IO_GUARD_STATS_EN adds the viol_count output.
module io_guard
  import io_guard_pkg::*;
#(
  parameter int          SYNC_STAGES = 2,
  parameter int          VIOL_PULSE  = 4,
  parameter logic [15:0] PERM_RESET  = 16'h0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        iorq_n,
  input  logic        rd_n,
  input  logic        wr_n,
  input  logic        m1_n,
  input  logic [7:0]  addr,
  input  logic [7:0]  data,
  input  logic        virtual_enabled,
  input  logic        trap_state,
  input  logic        perm_we,
  input  logic [15:0] perm_wdata,
  input  logic        cap_ack,
  output logic        io_violation,
  output logic        cap_valid,
  output logic [7:0]  cap_addr,
  output logic [7:0]  cap_data,
  output logic        cap_write,
  output logic        cap_overrun,
  output logic [15:0] perm_mask
`ifdef IO_GUARD_STATS_EN
  ,
  output logic [7:0]  viol_count
`endif
);

  // Counter starts at VIOL_PULSE-1 so the PULSE state lasts VIOL_PULSE clocks
  localparam logic [3:0] PULSE_LOAD = 4'(VIOL_PULSE - 1);

  logic w_iorqS, w_rdS, w_wrS, w_m1S;
  logic w_ioCycle;
  logic w_violCond;
  logic w_evalViol;
  logic [3:0] w_group;
  viol_rec_t w_rec;

  guard_state_t r_state, w_nextState;
  logic [3:0]   r_pulseCnt, w_nextCnt;

  logic [PERM_GROUPS-1:0] r_permMask;
  viol_rec_t              r_capRec;
  logic                   r_capValid;
  logic                   r_capOverrun;

  io_sync #(.STAGES(SYNC_STAGES)) u_syncIorq (
    .clk(clk), .rst(rst), .i_async(iorq_n), .o_sync(w_iorqS)
  );
  io_sync #(.STAGES(SYNC_STAGES)) u_syncRd (
    .clk(clk), .rst(rst), .i_async(rd_n), .o_sync(w_rdS)
  );
  io_sync #(.STAGES(SYNC_STAGES)) u_syncWr (
    .clk(clk), .rst(rst), .i_async(wr_n), .o_sync(w_wrS)
  );
  io_sync #(.STAGES(SYNC_STAGES)) u_syncM1 (
    .clk(clk), .rst(rst), .i_async(m1_n), .o_sync(w_m1S)
  );

  // A genuine I/O cycle: IORQ low, M1 high (not INTA), exactly one of RD/WR low
  assign w_ioCycle = !w_iorqS && w_m1S && (w_rdS ^ w_wrS);

  // Record presented at the evaluation edge; IN cycles carry no data
  assign w_group       = addr[7:GROUP_SHIFT];
  assign w_rec.addr    = addr;
  assign w_rec.write   = !w_wrS;
  assign w_rec.data    = w_wrS ? 8'h00 : data;

  // The mask register still holds the old value during a coinciding write
  assign w_violCond = isViolation(virtual_enabled, trap_state, r_permMask, w_group);

  // Next-state and pulse-counter logic for the monitor FSM
  always_comb begin
    w_nextState = r_state;
    w_nextCnt   = r_pulseCnt;
    w_evalViol  = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_ioCycle) begin
          if (w_violCond) begin
            w_evalViol  = 1'b1;
            w_nextState = ST_PULSE;
            w_nextCnt   = PULSE_LOAD;
          end else begin
            w_nextState = ST_ACTIVE;
          end
        end
      end
      ST_ACTIVE: begin
        if (w_iorqS) begin
          w_nextState = ST_IDLE;
        end
      end
      ST_PULSE: begin
        if (r_pulseCnt == 4'd0) begin
          w_nextState = w_iorqS ? ST_IDLE : ST_ACTIVE;
        end else begin
          w_nextCnt = r_pulseCnt - 4'd1;
        end
      end
      default: begin
        w_nextState = ST_IDLE;
      end
    endcase
  end

  // FSM state and pulse down-counter registers
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= ST_IDLE;
      r_pulseCnt <= 4'd0;
    end else begin
      r_state    <= w_nextState;
      r_pulseCnt <= w_nextCnt;
    end
  end

  // Allow mask: writable only from trap mode or with virtualisation off
  always_ff @(posedge clk) begin
    if (rst) begin
      r_permMask <= PERM_RESET;
    end else if (perm_we && (trap_state || !virtual_enabled)) begin
      r_permMask <= perm_wdata;
    end
  end

  // Violation record: first violation is kept, later ones only flag overrun;
  // an ack arriving with a new violation lets the new record replace the old
  always_ff @(posedge clk) begin
    if (rst) begin
      r_capRec     <= '0;
      r_capValid   <= 1'b0;
      r_capOverrun <= 1'b0;
    end else if (w_evalViol && (!r_capValid || cap_ack)) begin
      r_capRec     <= w_rec;
      r_capValid   <= 1'b1;
      r_capOverrun <= 1'b0;
    end else if (w_evalViol) begin
      r_capOverrun <= 1'b1;
    end else if (cap_ack) begin
      r_capValid   <= 1'b0;
      r_capOverrun <= 1'b0;
    end
  end

`ifdef IO_GUARD_STATS_EN
  logic [7:0] r_violCount;

  // Saturating violation counter, cleared by the hypervisor's ack
  always_ff @(posedge clk) begin
    if (rst) begin
      r_violCount <= 8'h00;
    end else if (w_evalViol) begin
      if (cap_ack) begin
        r_violCount <= 8'h01;
      end else if (r_violCount != 8'hFF) begin
        r_violCount <= r_violCount + 8'h01;
      end
    end else if (cap_ack) begin
      r_violCount <= 8'h00;
    end
  end

  assign viol_count = r_violCount;
`endif

  assign io_violation = (r_state == ST_PULSE);
  assign cap_valid    = r_capValid;
  assign cap_addr     = r_capRec.addr;
  assign cap_data     = r_capRec.data;
  assign cap_write    = r_capRec.write;
  assign cap_overrun  = r_capOverrun;
  assign perm_mask    = r_permMask;

endmodule

// File: tb/tb_io_guard.sv
// Directed self-checking bench for io_guard (default parameters).
// Drives whole Z80 I/O cycles, counts io_violation clocks and checks the
// captured record, mask protection, INTA filtering, ack/capture collision
// and reset during a pulse. Stats checks compile in with IO_GUARD_STATS_EN.
module tb_io_guard;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        iorq_n = 1'b1, rd_n = 1'b1, wr_n = 1'b1, m1_n = 1'b1;
  logic [7:0]  addr = 8'h00, data = 8'h00;
  logic        virtual_enabled = 1'b0, trap_state = 1'b0;
  logic        perm_we = 1'b0;
  logic [15:0] perm_wdata = 16'h0000;
  logic        cap_ack = 1'b0;
  logic        io_violation, cap_valid, cap_write, cap_overrun;
  logic [7:0]  cap_addr, cap_data;
  logic [15:0] perm_mask;
`ifdef IO_GUARD_STATS_EN
  logic [7:0]  viol_count;
`endif

  int nChecks = 0;
  int nErrors = 0;
  int pulses, rise;

  io_guard dut (
    .clk(clk), .rst(rst),
    .iorq_n(iorq_n), .rd_n(rd_n), .wr_n(wr_n), .m1_n(m1_n),
    .addr(addr), .data(data),
    .virtual_enabled(virtual_enabled), .trap_state(trap_state),
    .perm_we(perm_we), .perm_wdata(perm_wdata), .cap_ack(cap_ack),
    .io_violation(io_violation), .cap_valid(cap_valid),
    .cap_addr(cap_addr), .cap_data(cap_data), .cap_write(cap_write),
    .cap_overrun(cap_overrun), .perm_mask(perm_mask)
`ifdef IO_GUARD_STATS_EN
    , .viol_count(viol_count)
`endif
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    nChecks++;
    if (obs !== exp) begin
      nErrors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One bus cycle: strobes held 8 clocks, 16-clock window; reports how many
  // clocks io_violation was high and the first clock it was seen high
  task automatic applyStimulus(input logic [7:0] a, input logic [7:0] d,
                               input logic isWrite, input logic isIntAck,
                               output int nPulse, output int firstRise);
    nPulse = 0;
    firstRise = 0;
    addr   = a;
    data   = d;
    iorq_n = 1'b0;
    m1_n   = ~isIntAck;
    rd_n   = isIntAck ? 1'b1 : isWrite;
    wr_n   = isIntAck ? 1'b1 : ~isWrite;
    for (int i = 1; i <= 16; i++) begin
      tick();
      if (io_violation) begin
        nPulse++;
        if (firstRise == 0) firstRise = i;
      end
      if (i == 8) begin
        iorq_n = 1'b1;
        rd_n   = 1'b1;
        wr_n   = 1'b1;
        m1_n   = 1'b1;
      end
    end
  endtask

  task automatic writeMask(input logic [15:0] val);
    perm_we    = 1'b1;
    perm_wdata = val;
    tick();
    perm_we    = 1'b0;
    tick();
  endtask

  task automatic ackRecord();
    cap_ack = 1'b1;
    tick();
    cap_ack = 1'b0;
  endtask

  initial begin
    repeat (3) tick();
    checkOutput("rst_viol", {15'd0, io_violation}, 16'h0);
    checkOutput("rst_valid", {15'd0, cap_valid}, 16'h0);
    checkOutput("rst_overrun", {15'd0, cap_overrun}, 16'h0);
    checkOutput("rst_addr", {8'd0, cap_addr}, 16'h0);
    checkOutput("rst_mask", perm_mask, 16'h0000);
    rst = 1'b0;
    virtual_enabled = 1'b1;
    trap_state = 1'b0;
    tick();

    // OUT (0x40),0xA5 with an all-trap mask
    applyStimulus(8'h40, 8'hA5, 1'b1, 1'b0, pulses, rise);
    checkOutput("out40_pulses", 16'(pulses), 16'd4);
    checkOutput("out40_latency", 16'(rise), 16'd3);
    checkOutput("out40_addr", {8'd0, cap_addr}, 16'h0040);
    checkOutput("out40_data", {8'd0, cap_data}, 16'h00A5);
    checkOutput("out40_write", {15'd0, cap_write}, 16'h1);
    checkOutput("out40_valid", {15'd0, cap_valid}, 16'h1);
    ackRecord();
    checkOutput("ack_valid", {15'd0, cap_valid}, 16'h0);

    // Allow group 4 from trap mode
    trap_state = 1'b1;
    writeMask(16'h0010);
    checkOutput("mask_write", perm_mask, 16'h0010);
    trap_state = 1'b0;
    applyStimulus(8'h4F, 8'h77, 1'b0, 1'b0, pulses, rise);
    checkOutput("in4F_pulses", 16'(pulses), 16'd0);
    checkOutput("in4F_valid", {15'd0, cap_valid}, 16'h0);
    applyStimulus(8'h50, 8'h77, 1'b0, 1'b0, pulses, rise);
    checkOutput("in50_pulses", 16'(pulses), 16'd4);
    checkOutput("in50_addr", {8'd0, cap_addr}, 16'h0050);
    checkOutput("in50_write", {15'd0, cap_write}, 16'h0);
    checkOutput("in50_data", {8'd0, cap_data}, 16'h0000);
    ackRecord();

    // Two violations without ack: first record kept, overrun flagged
    applyStimulus(8'h10, 8'h11, 1'b1, 1'b0, pulses, rise);
    checkOutput("ovr1_pulses", 16'(pulses), 16'd4);
    applyStimulus(8'h20, 8'h22, 1'b1, 1'b0, pulses, rise);
    checkOutput("ovr2_pulses", 16'(pulses), 16'd4);
    checkOutput("ovr_addr", {8'd0, cap_addr}, 16'h0010);
    checkOutput("ovr_data", {8'd0, cap_data}, 16'h0011);
    checkOutput("ovr_flag", {15'd0, cap_overrun}, 16'h1);
    ackRecord();
    checkOutput("ovr_ack_valid", {15'd0, cap_valid}, 16'h0);
    checkOutput("ovr_ack_flag", {15'd0, cap_overrun}, 16'h0);

    // Interrupt acknowledge at port 0x00 (group 0 trapped) is ignored
    applyStimulus(8'h00, 8'hFF, 1'b0, 1'b1, pulses, rise);
    checkOutput("inta_pulses", 16'(pulses), 16'd0);
    checkOutput("inta_valid", {15'd0, cap_valid}, 16'h0);

    // Mask protected while virtualised outside trap mode, open when not virtualised
    writeMask(16'hFFFF);
    checkOutput("mask_locked", perm_mask, 16'h0010);
    virtual_enabled = 1'b0;
    writeMask(16'h0000);
    checkOutput("mask_virt_off", perm_mask, 16'h0000);
    virtual_enabled = 1'b1;

    // Trap mode suppresses violations
    trap_state = 1'b1;
    applyStimulus(8'h30, 8'h33, 1'b1, 1'b0, pulses, rise);
    checkOutput("trap_pulses", 16'(pulses), 16'd0);
    checkOutput("trap_valid", {15'd0, cap_valid}, 16'h0);
    trap_state = 1'b0;

    // Ack coinciding with a new capture: new record wins, overrun cleared
    applyStimulus(8'h60, 8'h66, 1'b1, 1'b0, pulses, rise);
    applyStimulus(8'h61, 8'h67, 1'b1, 1'b0, pulses, rise);
    checkOutput("coll_pre_ovr", {15'd0, cap_overrun}, 16'h1);
    addr = 8'h70; data = 8'h7E; iorq_n = 1'b0; wr_n = 1'b0;
    tick();
    tick();
    cap_ack = 1'b1;
    tick();
    cap_ack = 1'b0;
    checkOutput("coll_viol", {15'd0, io_violation}, 16'h1);
    checkOutput("coll_valid", {15'd0, cap_valid}, 16'h1);
    checkOutput("coll_addr", {8'd0, cap_addr}, 16'h0070);
    checkOutput("coll_data", {8'd0, cap_data}, 16'h007E);
    checkOutput("coll_ovr", {15'd0, cap_overrun}, 16'h0);
    repeat (5) tick();
    iorq_n = 1'b1; wr_n = 1'b1;
    repeat (6) tick();

    // Reset in the middle of a pulse
    ackRecord();
    addr = 8'h80; data = 8'h88; iorq_n = 1'b0; wr_n = 1'b0;
    repeat (3) tick();
    checkOutput("midrst_pre", {15'd0, io_violation}, 16'h1);
    rst = 1'b1;
    tick();
    checkOutput("midrst_viol", {15'd0, io_violation}, 16'h0);
    checkOutput("midrst_valid", {15'd0, cap_valid}, 16'h0);
    iorq_n = 1'b1; wr_n = 1'b1;
    repeat (3) tick();
    rst = 1'b0;
    tick();

`ifdef IO_GUARD_STATS_EN
    checkOutput("stats_rst", {8'd0, viol_count}, 16'h0000);
    for (int n = 0; n < 300; n++) begin
      applyStimulus(8'(n), 8'h5A, 1'b1, 1'b0, pulses, rise);
    end
    checkOutput("stats_sat", {8'd0, viol_count}, 16'h00FF);
    ackRecord();
    checkOutput("stats_ack", {8'd0, viol_count}, 16'h0000);
`endif

    $display("Result: errors=%0d of %0d checks", nErrors, nChecks);
    $finish;
  end

endmodule

// File: doc/io_guard.md
Name: io_guard

Overview:
- Synchronous I/O-cycle monitor that sits directly upstream of the trap/mode controller.
- Samples Z80 bus strobes on the system clock and classifies each I/O cycle against a group-permission mask.
- Emits the io_violation pulse consumed by the mode controller and captures a violation record (port, data, direction) for the hypervisor to read during trap handling.

Parameters:
- SYNC_STAGES, 2: synchroniser depth for iorq_n/rd_n/wr_n/m1_n; legal values are 2 or 3.
- VIOL_PULSE, 4: width in clk cycles of the io_violation pulse; legal range 1..15.
- PERM_RESET, 16'h0000: reset value of the allow mask; all groups trap.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous reset, active-high.
- iorq_n  in  1  Z80 IORQ, asynchronous.
- rd_n  in  1  Z80 RD, asynchronous.
- wr_n  in  1  Z80 WR, asynchronous.
- m1_n  in  1  Z80 M1, asynchronous.
- addr  in  8  Z80 A[7:0].
- data  in  8  Z80 D[7:0].
- virtual_enabled  in  1  virtualisation on.
- trap_state  in  1  mode controller trap flag.
- perm_we  in  1  single-cycle write strobe for the allow mask.
- perm_wdata  in  16  new allow mask; bit g permits ports g*16..g*16+15.
- cap_ack  in  1  single-cycle pulse; hypervisor has consumed the record.
- io_violation  out  1  violation pulse to the mode controller.
- cap_valid  out  1  record held.
- cap_addr  out  8  captured port.
- cap_data  out  8  captured write data; 8'h00 for reads.
- cap_write  out  1  1 = OUT, 0 = IN.
- cap_overrun  out  1  a violation was lost while a record was held.
- perm_mask  out  16  current allow mask.

Behaviour:
- Reset values: all outputs 0; perm_mask = PERM_RESET; FSM = IDLE; synchronisers filled with 1.
- Strobes pass through SYNC_STAGES flops. addr and data are registered in the same cycle that the synchronised strobe is first seen active.
- An I/O cycle is defined as synced iorq_n = 0 AND m1_n = 1, with exactly one of rd_n/wr_n low. iorq_n low with m1_n low is interrupt acknowledge and is ignored.
- FSM states:
  - IDLE: on an I/O cycle, latch addr, data and direction, evaluate, then go to ACTIVE.
  - ACTIVE: wait for synced iorq_n = 1, then return to IDLE. Exactly one evaluation per cycle; further strobe activity while in ACTIVE is ignored.
  - PULSE: entered from IDLE on a violation. io_violation = 1 for exactly VIOL_PULSE clocks, driven by a 4-bit down-counter. Then go to ACTIVE, or straight to IDLE if iorq_n has already returned high.
- Violation condition: virtual_enabled = 1 AND trap_state = 0 AND perm_mask[addr[7:4]] = 0. The condition is evaluated on the latched values.
- Latency: io_violation rises 1 clk after the synchronised strobe edge, i.e. SYNC_STAGES+1 clks after the pin edge.
- Capture: on a violation with cap_valid = 0, load cap_addr/cap_data/cap_write and set cap_valid. With cap_valid = 1, the record is not overwritten; cap_overrun is set instead. io_violation still pulses in this case.
- cap_ack clears cap_valid and cap_overrun on the next clk.
  - cap_ack in the same cycle as a new capture: the capture wins. cap_valid stays 1 with the new record and cap_overrun = 0.
- perm_we is accepted only while trap_state = 1 or virtual_enabled = 0; otherwise it is ignored. A write takes effect the next clk. A write coinciding with an evaluation uses the old mask.
- Reset mid-PULSE drops io_violation the next clk and clears the record.
- Violations while trap_state = 1 are never flagged; the mode controller handles its own trap-mode case.

Optional Feature:
- IO_GUARD_STATS_EN
  - Defined: adds output viol_count[7:0], a saturating count of violations (including overruns). It sticks at 8'hFF, is cleared by cap_ack, and is 0 on reset.
  - Undefined: the port is absent and no counter logic exists.

Decomposition:
- Shared package: FSM state encoding (IDLE/ACTIVE/PULSE), PERM_GROUPS = 16, GROUP_SHIFT = 4, and a violation-record struct (addr, data, write).
- One natural sub-module, io_sync, a parameterised SYNC_STAGES synchroniser instanced per strobe. Everything else stays flat.

Test Plan:
- After reset, with virtual_enabled = 1, trap_state = 0 and mask 0: OUT (0x40),0xA5 -> io_violation high 4 clks; cap_addr = 0x40, cap_data = 0xA5, cap_write = 1, cap_valid = 1.
- Mask 16'h0010 written while trap_state = 1; then IN 0x4F with trap_state = 0 -> no pulse; IN 0x50 -> pulse, cap_write = 0, cap_data = 0x00.
- Two violations (0x10, then 0x20) without ack -> two pulses; cap_addr stays 0x10 and cap_overrun = 1. cap_ack -> both clear.
- Interrupt acknowledge (iorq_n and m1_n low together) at port 0x00 with mask 0 -> no pulse, no capture.
- perm_we with trap_state = 0 and virtual_enabled = 1 -> perm_mask unchanged. rst asserted mid-pulse -> io_violation 0 the next clk and cap_valid = 0.
- IO_GUARD_STATS_EN defined: 300 violations -> viol_count = 0xFF; cap_ack -> 0.
